reg_group_p: RTL and testbench
==============================

Name: reg_group_p

Overview:
- Parametrised register file for the model machine datapath, one generation on from the fixed 3x8-bit group.
- Width and register count are set by parameters. One index can be hardwired to read as zero, matching the existing "index 2 reads 0" decode.
- Adds synchronous reset and a post-increment (pointer) operation on the write-addressed register.
- Feeds the ALU operand buses (s, d) and accepts results from the result bus (i).

Parameters:
- WIDTH, 8, data width of each register and of i/s/d.
- NREGS, 4, number of register slots; must be a power of two, >=2; AW = log2(NREGS).
- ZERO_IDX, 2, index that always reads 0 and ignores writes/increments; set to NREGS or more to disable (every index is then a real register).
- RST_VAL, 0, value loaded into every real register on reset (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on falling edge.
- rst  input  1  synchronous reset, active-low; sampled on falling edge of clk.
- we  input  1  write enable, active-low.
- inc  input  1  post-increment request for register rwba, active-high.
- raa  input  AW  source read address, drives s.
- rwba  input  AW  destination address: read for d, target of write/increment.
- i  input  WIDTH  write data.
- s  output  WIDTH  source operand, combinational.
- d  output  WIDTH  destination operand, combinational.

Behaviour:
- Storage: R[k] for every k != ZERO_IDX, WIDTH bits each. No storage exists for ZERO_IDX.
- Reads (combinational, zero latency):
  - s = 0 if raa == ZERO_IDX, else R[raa].
  - d = 0 if rwba == ZERO_IDX, else R[rwba].
  - No X on s/d for any in-range address.
- Reset: on falling clk with rst=0, every R[k] <= RST_VAL, so s/d read RST_VAL (or 0 at ZERO_IDX) immediately after.
  - Reset overrides we and inc in the same edge.
  - Reset asserted mid-sequence discards the in-flight write or increment.
- Write: on falling clk with rst=1 and we=0, R[rwba] <= i.
  - New value is visible on s/d after that edge.
  - Write to ZERO_IDX is a no-op.
- Increment: on falling clk with rst=1, we=1, inc=1, R[rwba] <= R[rwba] + 1, modulo 2^WIDTH.
  - Wraps from all-ones to 0; no carry out.
  - Increment of ZERO_IDX is a no-op.
- Priority per edge: rst=0 > we=0 > inc=1 > hold.
  - Simultaneous we=0 and inc=1 performs the write only; i is stored unincremented.
- Only R[rwba] changes in any edge; all other registers hold.
- raa == rwba is legal: s and d both show the same register.
- Back-to-back edges may target the same register; each edge uses the value left by the previous edge (e.g. two increments add 2).

Optional Feature:
- Macro: REG_BYPASS_EN.
- Defined: write-through forwarding. While rst=1 and we=0, a read whose address equals rwba (and != ZERO_IDX) returns i instead of the stored value. Applies to s when raa==rwba, and always to d. Increment is not forwarded. Stored behaviour is unchanged.
- Undefined: s/d always show stored contents; a write becomes visible only after the falling edge.

Test Plan:
- Reset (defaults): rst=0 for one falling edge with we=0, i=8'h55, rwba=0 -> R0,R1,R3 read 8'h00, index 2 reads 8'h00, and R0 is not 8'h55.
- Write/read all slots: write 8'h0A->0, 8'h0B->1, 8'hC0->3, 8'hFF->2 -> raa=0/1/3 give s=0A/0B/C0; raa=2 and rwba=2 give 0; d tracks rwba.
- Increment with wrap: R3=8'hFE, rwba=3, inc=1, we=1, three falling edges -> d = FF, 00, 01.
- Priority: R1=8'h10, rwba=1, we=0, inc=1, i=8'h20 -> R1=8'h20 (not 21). Same edge with rst=0 -> R1=8'h00.
- Parameter sweep: WIDTH=16, NREGS=8, ZERO_IDX=8 -> all 8 indices store distinct 16-bit values; R7=16'hFFFF incremented -> 16'h0000.
- Bypass: with REG_BYPASS_EN defined, R0=8'h01, rwba=raa=0, we=0, i=8'h77, before the edge -> s=d=8'h77. Without the macro -> s=d=8'h01 until the edge, then 8'h77.

Source files
------------

// File: rtl/reg_group_p_if.sv
// Operand/result bus of the parametrised register group.
// Master drives address/control/data, slave returns s and d.
interface reg_group_p_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             we;
    logic             inc;
    logic [AW-1:0]    raa;
    logic [AW-1:0]    rwba;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;

    modport master (
        output we, inc, raa, rwba, i,
        input  s, d
    );

    modport slave (
        input  we, inc, raa, rwba, i,
        output s, d
    );
endinterface

// File: rtl/reg_group_p.sv
// Parametrised register file with hardwired zero index and post-increment.
// Optional write-through forwarding when REG_BYPASS_EN is defined.
module reg_group_p #(
    parameter int               WIDTH    = 8,
    parameter int               NREGS    = 4,
    parameter int               ZERO_IDX = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    reg_group_p_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] q [NREGS];

    for (genvar k = 0; k < NREGS; k++) begin : g_reg
        if (k == ZERO_IDX) begin : g_zero
            assign q[k] = '0;
        end else begin : g_real
            logic [WIDTH-1:0] r;
            logic             sel;

            assign sel  = (bus.rwba == AW'(k));
            assign q[k] = r;

            // Registers update on the falling edge of clk.
            always_ff @(negedge clk) begin
                if (!rst)
                    r <= RST_VAL;
                else if (sel && !bus.we)
                    r <= bus.i;
                else if (sel && bus.inc)
                    r <= r + 1'b1;
            end
        end
    end

`ifdef REG_BYPASS_EN
    logic fwd_d;
    logic fwd_s;

    assign fwd_d = rst && !bus.we
                && (int'(bus.rwba) != ZERO_IDX);
    assign fwd_s = fwd_d && (bus.raa == bus.rwba);

    assign bus.s = fwd_s ? bus.i : q[bus.raa];
    assign bus.d = fwd_d ? bus.i : q[bus.rwba];
`else
    assign bus.s = q[bus.raa];
    assign bus.d = q[bus.rwba];
`endif
endmodule

// File: tb/tb_reg_group_p.sv
// Directed self-checking bench for reg_group_p.
// Covers default 8-bit/4-reg build and a 16-bit/8-reg no-zero build.
module tb_reg_group_p;
    logic clk = 1'b1;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_group_p_if #(.WIDTH(8), .AW(2)) b1 ();
    reg_group_p_if #(.WIDTH(16), .AW(3)) b2 ();

    reg_group_p #(
        .WIDTH(8), .NREGS(4), .ZERO_IDX(2), .RST_VAL(8'h00)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    reg_group_p #(
        .WIDTH(16), .NREGS(8), .ZERO_IDX(8), .RST_VAL(16'h0000)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(b2.slave)
    );

    // Advance past one active (falling) edge; inputs change after it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr1(input logic [1:0] a, input logic [7:0] v);
        b1.rwba = a;
        b1.i    = v;
        b1.we   = 1'b0;
        b1.inc  = 1'b0;
        step();
        b1.we   = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        b1.we = 1'b0; b1.inc = 1'b1; b1.i = 8'h55;
        b1.rwba = 2'd0; b1.raa = 2'd0;
        b2.we = 1'b1; b2.inc = 1'b0; b2.i = '0;
        b2.rwba = 3'd0; b2.raa = 3'd0;
        step();
        rst = 1'b1; b1.we = 1'b1; b1.inc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b1.raa = 2'(k); b1.rwba = 2'(k); #1;
            checks++;
            if (b1.s !== 8'h00) begin
                errors++;
                $display("FAIL reset_s%0d got %h exp 00", k, b1.s);
            end
            checks++;
            if (b1.d !== 8'h00) begin
                errors++;
                $display("FAIL reset_d%0d got %h exp 00", k, b1.d);
            end
        end
    endtask

    task automatic test_write_all();
        logic [7:0] exp [4];
        exp = '{8'h0A, 8'h0B, 8'h00, 8'hC0};
        wr1(2'd0, 8'h0A);
        wr1(2'd1, 8'h0B);
        wr1(2'd3, 8'hC0);
        wr1(2'd2, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            b1.raa = 2'(k); b1.rwba = 2'(3 - k); #1;
            checks++;
            if (b1.s !== exp[k]) begin
                errors++;
                $display("FAIL wr_s%0d got %h exp %h", k, b1.s, exp[k]);
            end
            checks++;
            if (b1.d !== exp[3-k]) begin
                errors++;
                $display("FAIL wr_d%0d got %h exp %h",
                         3 - k, b1.d, exp[3-k]);
            end
        end
    endtask

    task automatic test_increment();
        logic [7:0] exp [3];
        exp = '{8'hFF, 8'h00, 8'h01};
        wr1(2'd3, 8'hFE);
        b1.rwba = 2'd3; b1.we = 1'b1; b1.inc = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (b1.d !== exp[n]) begin
                errors++;
                $display("FAIL inc%0d got %h exp %h", n, b1.d, exp[n]);
            end
        end
        b1.inc = 1'b0;
        b1.raa = 2'd1; #1;
        checks++;
        if (b1.s !== 8'h0B) begin
            errors++;
            $display("FAIL inc_other got %h exp 0b", b1.s);
        end
    endtask

    task automatic test_back_to_back();
        b1.rwba = 2'd0; b1.we = 1'b1; b1.inc = 1'b1;
        step();
        step();
        b1.inc = 1'b0;
        checks++;
        if (b1.d !== 8'h0C) begin
            errors++;
            $display("FAIL b2b_inc got %h exp 0c", b1.d);
        end
        b1.rwba = 2'd2; b1.inc = 1'b1;
        step();
        b1.inc = 1'b0;
        checks++;
        if (b1.d !== 8'h00) begin
            errors++;
            $display("FAIL zero_inc got %h exp 00", b1.d);
        end
    endtask

    task automatic test_priority();
        wr1(2'd1, 8'h10);
        b1.rwba = 2'd1; b1.we = 1'b0; b1.inc = 1'b1; b1.i = 8'h20;
        step();
        b1.we = 1'b1; b1.inc = 1'b0;
        checks++;
        if (b1.d !== 8'h20) begin
            errors++;
            $display("FAIL prio_we got %h exp 20", b1.d);
        end
        wr1(2'd1, 8'h10);
        rst = 1'b0; b1.we = 1'b0; b1.inc = 1'b1; b1.i = 8'h20;
        step();
        rst = 1'b1; b1.we = 1'b1; b1.inc = 1'b0;
        checks++;
        if (b1.d !== 8'h00) begin
            errors++;
            $display("FAIL prio_rst got %h exp 00", b1.d);
        end
        b1.raa = 2'd3; #1;
        checks++;
        if (b1.s !== 8'h00) begin
            errors++;
            $display("FAIL prio_rst_r3 got %h exp 00", b1.s);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] v;
        for (int k = 0; k < 8; k++) begin
            b2.rwba = 3'(k);
            b2.i = 16'h1000 + 16'(k) * 16'h0111;
            b2.we = 1'b0;
            step();
        end
        b2.we = 1'b1;
        for (int k = 0; k < 8; k++) begin
            v = 16'h1000 + 16'(k) * 16'h0111;
            b2.raa = 3'(k); #1;
            checks++;
            if (b2.s !== v) begin
                errors++;
                $display("FAIL sweep_s%0d got %h exp %h", k, b2.s, v);
            end
        end
        b2.rwba = 3'd7; b2.i = 16'hFFFF; b2.we = 1'b0;
        step();
        b2.we = 1'b1; b2.inc = 1'b1;
        step();
        b2.inc = 1'b0;
        checks++;
        if (b2.d !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_wrap got %h exp 0000", b2.d);
        end
        b2.raa = 3'd6; #1;
        checks++;
        if (b2.s !== 16'h1666) begin
            errors++;
            $display("FAIL sweep_hold got %h exp 1666", b2.s);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] pre;
`ifdef REG_BYPASS_EN
        pre = 8'h77;
`else
        pre = 8'h01;
`endif
        wr1(2'd0, 8'h01);
        b1.raa = 2'd0; b1.rwba = 2'd0; b1.i = 8'h77; b1.we = 1'b0;
        #1;
        checks++;
        if (b1.s !== pre) begin
            errors++;
            $display("FAIL byp_pre_s got %h exp %h", b1.s, pre);
        end
        checks++;
        if (b1.d !== pre) begin
            errors++;
            $display("FAIL byp_pre_d got %h exp %h", b1.d, pre);
        end
        step();
        b1.we = 1'b1;
        checks++;
        if (b1.s !== 8'h77 || b1.d !== 8'h77) begin
            errors++;
            $display("FAIL byp_post got %h/%h exp 77", b1.s, b1.d);
        end
    endtask

    initial begin
        test_reset();
        test_write_all();
        test_increment();
        test_back_to_back();
        test_priority();
        test_sweep();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
